// File: rtl/uart_tx_dev.sv
// uart_tx_dev: memory-mapped 8N1 UART transmitter with a TX FIFO and a level IRQ.
// Defining UART_PARITY_EN inserts a parity bit (CTRL bit2: 0=even, 1=odd).
module uart_tx_dev #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_7F30,
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [29:0] Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ,
  output logic        txd
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  function automatic logic parity_bit(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

  logic [7:0]    fifo_r [FIFO_DEPTH];
  logic [AW-1:0] wptr_r, rptr_r;
  logic [CW-1:0] count_r;
  logic          ovf_r, irq_r, txd_r, par_r, par_n, txd_n;
  logic [2:0]    ctrl_r, bit_r, bit_n;
  logic [15:0]   div_r, fdiv_r, fdiv_n, cyc_r, cyc_n;
  logic [7:0]    shift_r, shift_n, head_s;
  state_t        state_r, state_n;
  logic          hit_s, empty_s, full_s, busy_s, push_s, push_ok_s, pop_s, bit_end_s;
  logic          wr_status_s, wr_ctrl_s, wr_div_s, unused_din_s;
  logic [3:0]    cnt4_s;
  logic [1:0]    sel_s;

  assign hit_s       = (Addr[29:2] == BASE_ADDR[31:4]);
  assign sel_s       = Addr[1:0];
  assign push_s      = WE && hit_s && (sel_s == 2'd0);
  assign wr_status_s = WE && hit_s && (sel_s == 2'd1);
  assign wr_ctrl_s   = WE && hit_s && (sel_s == 2'd2);
  assign wr_div_s    = WE && hit_s && (sel_s == 2'd3);
  assign empty_s     = (count_r == {CW{1'b0}});
  assign full_s      = (count_r == CNT_FULL);
  assign busy_s      = (state_r != S_IDLE);
  // A full FIFO still accepts a push when the transmitter pops in the same cycle.
  assign push_ok_s   = push_s && (!full_s || pop_s);
  assign head_s      = fifo_r[rptr_r];
  assign bit_end_s   = (cyc_r == (fdiv_r - 16'd1));
  assign cnt4_s      = 4'(count_r);
  assign unused_din_s = ^Din[31:16];
  assign IRQ = irq_r;
  assign txd = txd_r;

  // Register read mux; no hit reads as zero.
  always_comb begin
    Dout = 32'h0000_0000;
    if (hit_s) begin
      case (sel_s)
        2'd1:    Dout = {24'h00_0000, cnt4_s, ovf_r, empty_s, full_s, busy_s};
        2'd2:    Dout = {29'h0000_0000, ctrl_r};
        2'd3:    Dout = {16'h0000, div_r};
        default: Dout = 32'h0000_0000;
      endcase
    end else begin
      Dout = 32'h0000_0000;
    end
  end

  // FIFO storage, pointers, count and the CPU-visible control registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_r[i] <= 8'h00;
      wptr_r  <= {AW{1'b0}};
      rptr_r  <= {AW{1'b0}};
      count_r <= {CW{1'b0}};
      ovf_r   <= 1'b0;
      ctrl_r  <= 3'd0;
      div_r   <= DEFAULT_DIV;
    end else begin
      if (push_ok_s) begin
        fifo_r[wptr_r] <= Din[7:0];
        wptr_r         <= wptr_r + PTR_ONE;
      end
      if (pop_s) rptr_r <= rptr_r + PTR_ONE;
      case ({push_ok_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
      if (push_s && !push_ok_s) ovf_r <= 1'b1;
      else if (wr_status_s)     ovf_r <= 1'b0;
`ifdef UART_PARITY_EN
      if (wr_ctrl_s) ctrl_r <= Din[2:0];
`else
      if (wr_ctrl_s) ctrl_r <= {1'b0, Din[1:0]};
`endif
      if (wr_div_s) div_r <= (Din[15:0] == 16'd0) ? 16'd1 : Din[15:0];
    end
  end

  // Transmit FSM state and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= S_IDLE;
      cyc_r   <= 16'd0;
      bit_r   <= 3'd0;
      shift_r <= 8'h00;
      fdiv_r  <= DEFAULT_DIV;
      par_r   <= 1'b0;
      txd_r   <= 1'b1;
      irq_r   <= 1'b0;
    end else begin
      state_r <= state_n;
      cyc_r   <= cyc_n;
      bit_r   <= bit_n;
      shift_r <= shift_n;
      fdiv_r  <= fdiv_n;
      par_r   <= par_n;
      txd_r   <= txd_n;
      irq_r   <= ctrl_r[1] && empty_s && (state_r == S_IDLE);
    end
  end

  // Next-state logic; txd is computed one edge ahead so the line is registered.
  always_comb begin
    state_n = state_r;
    cyc_n   = cyc_r;
    bit_n   = bit_r;
    shift_n = shift_r;
    fdiv_n  = fdiv_r;
    par_n   = par_r;
    txd_n   = txd_r;
    pop_s   = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (ctrl_r[0] && !empty_s) begin
          pop_s   = 1'b1;
          state_n = S_START;
          shift_n = head_s;
          fdiv_n  = div_r;
          par_n   = parity_bit(head_s, ctrl_r[2]);
          cyc_n   = 16'd0;
          txd_n   = 1'b0;
        end else begin
          txd_n = 1'b1;
        end
      end
      S_START: begin
        if (bit_end_s) begin
          state_n = S_DATA;
          cyc_n   = 16'd0;
          bit_n   = 3'd0;
          txd_n   = shift_r[0];
        end else begin
          cyc_n = cyc_r + 16'd1;
        end
      end
      S_DATA: begin
        if (bit_end_s) begin
          cyc_n = 16'd0;
          if (bit_r == 3'd7) begin
`ifdef UART_PARITY_EN
            state_n = S_PARITY;
            txd_n   = par_r;
`else
            state_n = S_STOP;
            txd_n   = 1'b1;
`endif
          end else begin
            bit_n   = bit_r + 3'd1;
            shift_n = {1'b0, shift_r[7:1]};
            txd_n   = shift_r[1];
          end
        end else begin
          cyc_n = cyc_r + 16'd1;
        end
      end
      S_PARITY: begin
        if (bit_end_s) begin
          state_n = S_STOP;
          cyc_n   = 16'd0;
          txd_n   = 1'b1;
        end else begin
          cyc_n = cyc_r + 16'd1;
        end
      end
      S_STOP: begin
        if (bit_end_s) begin
          state_n = S_IDLE;
          cyc_n   = 16'd0;
          txd_n   = 1'b1;
        end else begin
          cyc_n = cyc_r + 16'd1;
        end
      end
      default: begin
        state_n = S_IDLE;
        cyc_n   = 16'd0;
        txd_n   = 1'b1;
      end
    endcase
  end
endmodule

// File: tb/tb_uart_tx_dev.sv
// Self-checking bench for uart_tx_dev: register table, directed frame timing,
// and randomized FIFO/frame traffic checked by a bit-level UART receiver model.
module tb_uart_tx_dev;
  localparam logic [31:0] BASE = 32'h0000_7F30;
`ifdef UART_PARITY_EN
  localparam int NBITS = 11;
  localparam logic [31:0] CTRL_MASK = 32'h0000_0007;
`else
  localparam int NBITS = 10;
  localparam logic [31:0] CTRL_MASK = 32'h0000_0003;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [29:0] Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;
  logic        txd;

  uart_tx_dev dut (
    .clk(clk), .reset(reset), .Addr(Addr), .WE(WE),
    .Din(Din), .Dout(Dout), .IRQ(IRQ), .txd(txd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        do_wr;
    logic [3:0]  off;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t        tbl [12];
  int          nvec = 0;
  int          nerr = 0;
  logic        cur_odd = 1'b0;
  logic [7:0]  got, got2, v, b;
  int          idle, bad, idle2, bad2, d, n, idx;
  logic        ien, ovf, expb;
  logic [7:0]  q[$];

  function automatic logic [29:0] ra(input logic [3:0] off);
    return 30'((BASE + {28'h000_0000, off}) >> 2);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic wr_raw(input logic [29:0] a, input logic [31:0] dat);
    @(negedge clk);
    Addr = a; Din = dat; WE = 1'b1;
    @(posedge clk);
    #1 WE = 1'b0;
  endtask

  task automatic wr(input logic [3:0] off, input logic [31:0] dat);
    wr_raw(ra(off), dat);
  endtask

  task automatic rd_chk(input string name, input logic [3:0] off, input logic [31:0] exp);
    Addr = ra(off);
    #1 chk(name, Dout, exp);
  endtask

  // Receiver model: waits for a start bit, checks each bit is held div cycles.
  task automatic rx_frame(input int div, output logic [7:0] data, output int idl, output int bd);
    logic [NBITS-1:0] bits;
    logic s;
    data = 8'h00; idl = 0; bd = 0; bits = {NBITS{1'b0}};
    @(negedge clk);
    while (txd === 1'b1 && idl < 400) begin
      idl++;
      @(negedge clk);
    end
    if (txd !== 1'b0) begin
      bd = 1;
      return;
    end
    for (int i = 0; i < NBITS * div; i++) begin
      if (i > 0) @(negedge clk);
      s = txd;
      if (i % div == 0) bits[i / div] = s;
      else if (s !== bits[i / div]) bd = 1;
    end
    if (bits[NBITS-1] !== 1'b1) bd = 1;
    data = bits[8:1];
`ifdef UART_PARITY_EN
    chk("parity_bit", {31'h0, bits[9]}, {31'h0, (^bits[8:1]) ^ cur_odd});
`endif
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1'b0, 4'h4, 32'h0000_0000, 32'h0000_0004};
    tbl[1]  = '{1'b0, 4'hC, 32'h0000_0000, 32'd434};
    tbl[2]  = '{1'b0, 4'h8, 32'h0000_0000, 32'h0000_0000};
    tbl[3]  = '{1'b0, 4'h0, 32'h0000_0000, 32'h0000_0000};
    tbl[4]  = '{1'b1, 4'hC, 32'h0000_0000, 32'h0000_0001};
    tbl[5]  = '{1'b1, 4'hC, 32'hABCD_0005, 32'h0000_0005};
    tbl[6]  = '{1'b1, 4'hC, 32'h0001_FFFF, 32'h0000_FFFF};
    tbl[7]  = '{1'b1, 4'h8, 32'hFFFF_FFF8, 32'h0000_0000};
    tbl[8]  = '{1'b1, 4'h8, 32'hFFFF_FFFE, 32'hFFFF_FFFE & CTRL_MASK};
    tbl[9]  = '{1'b1, 4'h8, 32'h0000_0007, 32'h0000_0007 & CTRL_MASK};
    tbl[10] = '{1'b1, 4'h8, 32'h0000_0000, 32'h0000_0000};
    tbl[11] = '{1'b1, 4'h4, 32'hFFFF_FFFF, 32'h0000_0004};

    reset = 1'b1; WE = 1'b0; Addr = 30'h0; Din = 32'h0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_txd", {31'h0, txd}, 32'h1);
    chk("reset_irq", {31'h0, IRQ}, 32'h0);

    for (int i = 0; i < 12; i++) begin
      if (tbl[i].do_wr) wr(tbl[i].off, tbl[i].wdata);
      rd_chk($sformatf("reg_vec%0d", i), tbl[i].off, tbl[i].exp);
    end

    Addr = ra(4'hC) ^ 30'h0000_0004;
    #1 chk("nohit_read", Dout, 32'h0);
    wr_raw(ra(4'hC) ^ 30'h0000_0004, 32'h0000_0003);
    rd_chk("nohit_write", 4'hC, 32'h0000_FFFF);

    // Single frame of 8'hA5 with a 4-cycle bit period.
    wr(4'hC, 32'd4);
    wr(4'h8, 32'h1);
    v = 8'hA5;
    wr(4'h0, {24'h0, v});
    @(negedge clk);
    chk("a5_pre_start", {31'h0, txd}, 32'h1);
    for (int k = 1; k <= NBITS * 4; k++) begin
      @(negedge clk);
      idx = (k - 1) / 4;
      if (idx == 0)              expb = 1'b0;
      else if (idx <= 8)         expb = v[idx-1];
      else if (idx == NBITS - 1) expb = 1'b1;
      else                       expb = (^v) ^ cur_odd;
      chk($sformatf("a5_txd_k%0d", k), {31'h0, txd}, {31'h0, expb});
    end
    rd_chk("a5_busy_last", 4'h4, 32'h0000_0005);
    @(negedge clk);
    rd_chk("a5_idle_after", 4'h4, 32'h0000_0004);

    // Overflow with transmitter disabled, then drain in order.
    wr(4'h8, 32'h0);
    wr(4'hC, 32'd2);
    for (int i = 1; i <= 5; i++) wr(4'h0, 32'(i * 17));
    rd_chk("ovf_status", 4'h4, 32'h0000_004A);
    wr(4'h4, 32'h0);
    rd_chk("ovf_cleared", 4'h4, 32'h0000_0042);
    wr(4'h8, 32'h1);
    for (int i = 1; i <= 4; i++) begin
      rx_frame(2, got, idle, bad);
      chk("ovf_byte", {24'h0, got}, 32'(i * 17));
      chk("ovf_frame_ok", 32'(bad), 32'h0);
      chk("ovf_gap", 32'(idle), 32'h1);
    end

    // IRQ timing around a push, frame end and irq_en clear.
    wr(4'h8, 32'h3);
    wr(4'h0, 32'h0000_005A);
    @(negedge clk);
    chk("irq_at_push", {31'h0, IRQ}, 32'h1);
    @(negedge clk);
    chk("irq_after_push", {31'h0, IRQ}, 32'h0);
    repeat (NBITS * 2) @(negedge clk);
    chk("irq_at_idle", {31'h0, IRQ}, 32'h0);
    @(negedge clk);
    chk("irq_after_idle", {31'h0, IRQ}, 32'h1);
    wr(4'h8, 32'h1);
    @(negedge clk);
    chk("irq_clear_edge", {31'h0, IRQ}, 32'h1);
    @(negedge clk);
    chk("irq_cleared", {31'h0, IRQ}, 32'h0);

    // DIV change mid-frame only affects the following frame.
    wr(4'h8, 32'h0);
    wr(4'hC, 32'd2);
    wr(4'h0, 32'h0000_003C);
    wr(4'h0, 32'h0000_00C3);
    wr(4'h8, 32'h1);
    fork
      begin
        rx_frame(2, got, idle, bad);
        rx_frame(8, got2, idle2, bad2);
      end
      begin
        repeat (3) @(posedge clk);
        wr(4'hC, 32'd8);
      end
    join
    chk("div_frame1_byte", {24'h0, got}, 32'h3C);
    chk("div_frame1_ok", 32'(bad), 32'h0);
    chk("div_frame2_byte", {24'h0, got2}, 32'hC3);
    chk("div_frame2_ok", 32'(bad2), 32'h0);
    chk("div_frame2_gap", 32'(idle2), 32'h1);

    // Randomized traffic against the receiver model and a FIFO occupancy model.
    wr(4'h8, 32'h0);
    for (int it = 0; it < 6; it++) begin
      d   = $urandom_range(1, 4);
      n   = $urandom_range(1, 6);
      ien = 1'($urandom_range(0, 1));
      q.delete();
      ovf = 1'b0;
      wr(4'hC, 32'(d));
      wr(4'h4, 32'h0);
      for (int j = 0; j < n; j++) begin
        b = 8'($urandom);
        if (q.size() < 4) q.push_back(b);
        else ovf = 1'b1;
        wr(4'h0, {24'h0, b});
      end
      rd_chk("rnd_status", 4'h4, {24'h0, 4'(q.size()), ovf, 1'b0, q.size() == 4, 1'b0});
      wr(4'h8, {30'h0, ien, 1'b1});
      for (int j = 0; j < q.size(); j++) begin
        rx_frame(d, got, idle, bad);
        chk("rnd_byte", {24'h0, got}, {24'h0, q[j]});
        chk("rnd_frame_ok", 32'(bad), 32'h0);
        chk("rnd_gap", 32'(idle), 32'h1);
      end
      @(negedge clk);
      chk("rnd_irq_idle_edge", {31'h0, IRQ}, 32'h0);
      @(negedge clk);
      chk("rnd_irq", {31'h0, IRQ}, {31'h0, ien});
      rd_chk("rnd_done_status", 4'h4, {28'h0, ovf, 3'b100});
      wr(4'h8, 32'h0);
    end

`ifdef UART_PARITY_EN
    wr(4'hC, 32'd2);
    cur_odd = 1'b1;
    wr(4'h8, 32'h5);
    wr(4'h0, 32'h0000_0003);
    rx_frame(2, got, idle, bad);
    chk("par_odd_byte", {24'h0, got}, 32'h03);
    chk("par_odd_ok", 32'(bad), 32'h0);
    cur_odd = 1'b0;
    wr(4'h8, 32'h1);
    wr(4'h0, 32'h0000_0003);
    rx_frame(2, got, idle, bad);
    chk("par_even_byte", {24'h0, got}, 32'h03);
    chk("par_even_ok", 32'(bad), 32'h0);
`endif

    // Asynchronous reset in the middle of a frame of zero data bits.
    wr(4'h8, 32'h0);
    wr(4'hC, 32'd4);
    wr(4'h0, 32'h0000_0000);
    wr(4'h0, 32'h0000_0000);
    wr(4'h8, 32'h1);
    repeat (12) @(negedge clk);
    chk("pre_reset_txd", {31'h0, txd}, 32'h0);
    #2 reset = 1'b1;
    #1 chk("reset_txd_async", {31'h0, txd}, 32'h1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    rd_chk("post_reset_status", 4'h4, 32'h0000_0004);
    rd_chk("post_reset_div", 4'hC, 32'd434);
    rd_chk("post_reset_ctrl", 4'h8, 32'h0);
    repeat (5) @(negedge clk);
    chk("post_reset_txd", {31'h0, txd}, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
